// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk cycles
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   enable      capture enable; low forces IDLE and clears counters and flags
//   pwm_in      asynchronous PWM input
//   period_cnt  last measured period, rising edge to rising edge
//   high_cnt    last measured high time, rising edge to falling edge
//   meas_valid  one-cycle pulse when period_cnt/high_cnt update
//   stuck_high  input held high for TIMEOUT cycles
//   stuck_low   input held low for TIMEOUT cycles
//   overflow    last reported period saturated the counter
module pwm_capture #(
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic [CNT_WIDTH-1:0] high_cnt,
  output logic                 meas_valid,
  output logic                 stuck_high,
  output logic                 stuck_low,
  output logic                 overflow
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] IDLE_MAX = CNT_WIDTH'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   prev, sync, rise, fall, sat, timeout;
  logic [CNT_WIDTH-1:0]   cnt, idle, high_lat;
  assign sync = sync_ff[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
  // an edge in the same cycle always beats the timeout
  assign timeout = (idle == IDLE_MAX) & ~rise & ~fall;
  // both edges pass through the same chain, so measured intervals are exact
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_ff <= '0;
      prev    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
      prev    <= sync;
    end
  // cnt restarts at 1 on every rise so it reads the interval length at the next edge;
  // sat remembers that cnt sat at its ceiling while it still had to grow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      sat  <= 1'b0;
      idle <= '0;
    end else if (!enable) begin
      cnt  <= '0;
      sat  <= 1'b0;
      idle <= '0;
    end else begin
      cnt  <= rise ? CNT_WIDTH'(1) : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      sat  <= rise ? 1'b0 : sat | (cnt == CNT_MAX);
      idle <= (rise | fall) ? '0 : (idle == IDLE_MAX) ? idle : idle + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      high_lat   <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
      overflow   <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise | fall) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end
      if (state != IDLE && timeout) begin
        stuck_high <= sync;
        stuck_low  <= ~sync;
        state      <= ARM;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM:  if (rise) state <= HIGH;
          HIGH: if (fall) begin
            high_lat <= cnt;
            state    <= LOW;
          end
          LOW:  if (rise) begin
            period_cnt <= cnt;
            high_cnt   <= high_lat;
            overflow   <= sat;
            meas_valid <= 1'b1;
            state      <= HIGH;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture (default build plus a 4-bit overflow build)
module tb_pwm_capture;
  typedef struct packed {
    logic [15:0] p;
    logic [15:0] h;
    logic        o;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n, enable, pwm_in, en_s, pwm_s;
  logic [15:0] period_cnt, high_cnt;
  logic        meas_valid, stuck_high, stuck_low, overflow;
  logic [3:0]  period_s, high_s;
  logic        valid_s, sh_s, sl_s, ovf_s;
  int          checks = 0;
  int          errors = 0;
  exp_t        q_main[$];
  exp_t        q_s[$];
  exp_t        e_main, e_s;
  always #5 clk = ~clk;
  pwm_capture dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_in(pwm_in),
    .period_cnt(period_cnt), .high_cnt(high_cnt), .meas_valid(meas_valid),
    .stuck_high(stuck_high), .stuck_low(stuck_low), .overflow(overflow)
  );
  pwm_capture #(.CNT_WIDTH(4), .TIMEOUT(12), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .pwm_in(pwm_s),
    .period_cnt(period_s), .high_cnt(high_s), .meas_valid(valid_s),
    .stuck_high(sh_s), .stuck_low(sl_s), .overflow(ovf_s)
  );
  function automatic exp_t mk(input int p, input int h, input bit o);
    mk.p = 16'(p);
    mk.h = 16'(h);
    mk.o = o;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drv(input bit s, input bit v, input int n);
    if (s) pwm_s = v;
    else pwm_in = v;
    repeat (n) @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (meas_valid) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected_valid got period=%0d high=%0d ovf=%0b", period_cnt, high_cnt, overflow);
      end else begin
        e_main = q_main.pop_front();
        if (period_cnt !== e_main.p || high_cnt !== e_main.h || overflow !== e_main.o) begin
          errors++;
          $display("FAIL main_meas got period=%0d high=%0d ovf=%0b expected period=%0d high=%0d ovf=%0b",
                   period_cnt, high_cnt, overflow, e_main.p, e_main.h, e_main.o);
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (valid_s) begin
      checks++;
      if (q_s.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected_valid got period=%0d high=%0d ovf=%0b", period_s, high_s, ovf_s);
      end else begin
        e_s = q_s.pop_front();
        if ({12'd0, period_s} !== e_s.p || {12'd0, high_s} !== e_s.h || ovf_s !== e_s.o) begin
          errors++;
          $display("FAIL small_meas got period=%0d high=%0d ovf=%0b expected period=%0d high=%0d ovf=%0b",
                   period_s, high_s, ovf_s, e_s.p, e_s.h, e_s.o);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog_timeout got no_finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0; enable = 1'b0; pwm_in = 1'b0; en_s = 1'b0; pwm_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_period", 32'(period_cnt), 0);
    chk("reset_high", 32'(high_cnt), 0);
    chk("reset_valid", 32'(meas_valid), 0);
    chk("reset_stuck", 32'({stuck_high, stuck_low}), 0);
    chk("reset_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    drv(0, 0, 5);
    repeat (4) q_main.push_back(mk(10, 3, 0));
    repeat (5) begin drv(0, 1, 3); drv(0, 0, 7); end
    q_main.push_back(mk(10, 3, 0));
    repeat (3) q_main.push_back(mk(10, 7, 0));
    repeat (4) begin drv(0, 1, 7); drv(0, 0, 3); end
    chk("steady_all_consumed", 32'(q_main.size()), 0);
    drv(0, 0, 990);
    chk("stuck_low_before_timeout", 32'(stuck_low), 0);
    drv(0, 0, 20);
    chk("stuck_low_set", 32'(stuck_low), 1);
    chk("stuck_low_only", 32'(stuck_high), 0);
    chk("stuck_low_period_hold", 32'(period_cnt), 10);
    chk("stuck_low_high_hold", 32'(high_cnt), 7);
    drv(0, 1, 4);
    chk("stuck_low_cleared_by_rise", 32'(stuck_low), 0);
    drv(0, 0, 6);
    repeat (2) q_main.push_back(mk(10, 4, 0));
    drv(0, 1, 4); drv(0, 0, 6);
    drv(0, 1, 1010);
    chk("stuck_high_set", 32'(stuck_high), 1);
    chk("stuck_high_only", 32'(stuck_low), 0);
    chk("stuck_high_period_hold", 32'(period_cnt), 10);
    chk("stuck_high_high_hold", 32'(high_cnt), 4);
    chk("stuck_high_overflow", 32'(overflow), 0);
    drv(0, 0, 5);
    chk("stuck_high_cleared_by_fall", 32'(stuck_high), 0);
    drv(0, 1, 3); drv(0, 0, 7);
    q_main.push_back(mk(10, 3, 0));
    drv(0, 1, 5);
    enable = 1'b0;
    drv(0, 1, 3);
    chk("disabled_valid", 32'(meas_valid), 0);
    chk("disabled_period_hold", 32'(period_cnt), 10);
    enable = 1'b1;
    drv(0, 0, 7);
    drv(0, 1, 3); drv(0, 0, 7);
    q_main.push_back(mk(10, 3, 0));
    drv(0, 1, 3); drv(0, 0, 7);
    chk("reenable_one_meas", 32'(q_main.size()), 0);
    drv(0, 1, 2);
    rst_n = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("midrun_reset_period", 32'(period_cnt), 0);
    chk("midrun_reset_high", 32'(high_cnt), 0);
    chk("midrun_reset_valid", 32'(meas_valid), 0);
    chk("midrun_reset_stuck", 32'({stuck_high, stuck_low}), 0);
    chk("midrun_reset_overflow", 32'(overflow), 0);
    drv(0, 0, 3);
    rst_n = 1'b1;
    drv(0, 0, 5);
    repeat (2) q_main.push_back(mk(10, 3, 0));
    repeat (2) begin drv(0, 1, 3); drv(0, 0, 7); end
    drv(0, 1, 3); drv(0, 0, 10);
    en_s = 1'b1;
    drv(1, 0, 5);
    repeat (3) q_s.push_back(mk(15, 6, 1));
    repeat (2) q_s.push_back(mk(15, 5, 0));
    repeat (3) begin drv(1, 1, 6); drv(1, 0, 11); end
    repeat (2) begin drv(1, 1, 5); drv(1, 0, 10); end
    drv(1, 1, 1); drv(1, 0, 5);
    chk("small_overflow_cleared", 32'(ovf_s), 0);
    for (int i = 0; i < 50 && (q_main.size() != 0 || q_s.size() != 0); i++) @(negedge clk);
    chk("main_queue_drained", 32'(q_main.size()), 0);
    chk("small_queue_drained", 32'(q_s.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
